disp_scan_mux: RTL and testbench
================================

DISP_SCAN_MUX -- requirements
Module: disp_scan_mux

Interface
REQ-001 Parameter DIV, default 50000: clock cycles per digit slot; legal range DIV >= 4.
REQ-002 Parameter BLANK, default 16: anode-off cycles at the start of each slot; legal range 1 <= BLANK < DIV.
REQ-003 Port clk, input, 1: single clock; all state on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port value_in, input, 16: four hex digits; digit 0 = [3:0], digit 3 = [15:12].
REQ-006 Port load, input, 1: one-cycle strobe capturing value_in.
REQ-007 Port dp_in, input, 4: per-digit decimal point request, 1 = lit.
REQ-008 Port lz_en, input, 1: 1 = suppress leading zeros.
REQ-009 Port nib, output, 4: hex nibble for the downstream 4-to-7-segment decoder.
REQ-010 Port an_n, output, 4: active-low digit anode enables.
REQ-011 Port dp_n, output, 1: active-low decimal point.
REQ-012 Port frame_start, output, 1: one-cycle pulse when the scan returns to digit 0.
REQ-013 Port pending, output, 1: 1 = a loaded value is waiting for the frame boundary.

Function
REQ-014 Slot counter cnt SHALL count 0..DIV-1 and wrap to 0; tick = (cnt == DIV-1).
REQ-015 Digit index idx SHALL advance on tick: 0->1->2->3->0.
REQ-016 Wrap 3->0 SHALL be the frame boundary; frame_start SHALL be 1 in the cycle after the boundary tick.
REQ-017 load=1 SHALL write value_in into pend and set pending=1; a later load before commit SHALL overwrite pend.
REQ-018 At the frame boundary tick with pending=1, disp_val SHALL take pend and pending SHALL clear.
REQ-019 load coincident with the frame boundary tick SHALL commit value_in directly to disp_val and leave pending=0.
REQ-020 dp_in and lz_en SHALL be sampled live each cycle, not latched.
REQ-021 Digit k SHALL be blank when lz_en=1, k>0, and disp_val nibbles k..3 are all zero; digit 0 SHALL never be blanked.
REQ-022 nib, an_n and dp_n SHALL be registered from the current cnt/idx/disp_val, giving one cycle of latency.
REQ-023 nib SHALL equal disp_val nibble idx.
REQ-024 When cnt < BLANK or the digit is blank, an_n SHALL be 4'b1111; otherwise an_n SHALL drive only bit idx low.
REQ-025 dp_n SHALL be 0 only when the digit's anode is active and dp_in[idx]=1; otherwise dp_n SHALL be 1.
REQ-026 At most one an_n bit SHALL be low in any cycle.

Reset
REQ-027 rst_n=0 SHALL asynchronously set cnt=0, idx=0, pend=0, disp_val=0, pending=0, nib=0, an_n=4'b1111, dp_n=1, frame_start=0.
REQ-028 After rst_n deasserts, scanning SHALL restart at digit 0, slot cycle 0.
REQ-029 Reset during a slot SHALL discard pend and darken all anodes immediately, without waiting for a clock edge.

Structure
REQ-030 Shared package disp_pkg SHALL hold NUM_DIGITS=4, ANODE_OFF=4'b1111, and the digit-index type (2 bits).
REQ-031 The prescaler (cnt and tick) SHALL be one sub-module, disp_tick_gen, parameterised by DIV.
REQ-032 The existing 4-to-7-segment decoder SHALL be instantiated outside this block and fed from nib.

Verification (DIV=8, BLANK=2)
REQ-033 Reset, then load value_in=16'h1234 -> digits show 4,3,2,1 for idx 0..3 (nib=4,3,2,1); an_n=1110,1101,1011,0111, each low for 6 of 8 cycles.
REQ-034 lz_en=1 with disp_val=16'h0050 -> digits 3 and 2 blank (an_n=1111 in their slots); digits 1 and 0 show 5 and 0.
REQ-035 lz_en=1 with disp_val=16'h0000 -> only digit 0 is lit, showing 0.
REQ-036 load 16'hAAAA in idx=1, then load 16'hBBBB in idx=2 -> disp_val stays at its old value until the frame boundary, then becomes 16'hBBBB; pending=1 until commit; frame_start pulses once.
REQ-037 load 16'hCAFE in the boundary tick cycle -> next frame shows CAFE and pending stays 0.
REQ-038 dp_in=4'b0100 -> dp_n=0 only while an_n=1011; assert rst_n=0 mid-slot -> an_n=1111 and dp_n=1 before the next clock edge.

Source files
------------

// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared constants, types and helpers for the multiplexed display scanner.
// No ports; imported by the interface, the prescaler and the top.
// -----------------------------------------------------------------------------
package disp_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned VAL_W      = NUM_DIGITS * NIB_W;

    // All anodes dark (active-low enables)
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    typedef logic [1:0]         digit_idx_t;
    typedef logic [NIB_W-1:0]   nibble_t;
    typedef logic [VAL_W-1:0]   disp_val_t;

    // Active-low one-cold anode pattern for a digit index
    function automatic logic [NUM_DIGITS-1:0] anode_sel(input digit_idx_t idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/disp_scan_mux_if.sv
// -----------------------------------------------------------------------------
// disp_scan_mux_if
// Groups the value/control inputs and display-drive outputs of disp_scan_mux.
//   value_in    : four hex digits, digit 0 in [3:0]
//   load        : one-cycle capture strobe for value_in
//   dp_in       : per-digit decimal point request (1 = lit)
//   lz_en       : leading-zero suppression enable
//   nib         : nibble for the external 7-segment decoder
//   an_n        : active-low anode enables
//   dp_n        : active-low decimal point
//   frame_start : pulse when the scan returns to digit 0
//   pending     : a loaded value is waiting for the frame boundary
// master = producer of value/control, slave = scanner.
// -----------------------------------------------------------------------------
interface disp_scan_mux_if;
    import disp_pkg::*;

    disp_val_t               value_in;
    logic                    load;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    lz_en;
    nibble_t                 nib;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    dp_n;
    logic                    frame_start;
    logic                    pending;

    modport master (
        output value_in, load, dp_in, lz_en,
        input  nib, an_n, dp_n, frame_start, pending
    );

    modport slave (
        input  value_in, load, dp_in, lz_en,
        output nib, an_n, dp_n, frame_start, pending
    );

endinterface

// File: rtl/disp_tick_gen.sv
// -----------------------------------------------------------------------------
// disp_tick_gen
// Slot prescaler: counts 0..DIV-1 and wraps; tick marks the last slot cycle.
//   clk, rst_n : clock, async active-low reset
//   cnt_o      : registered slot-cycle counter
//   tick_c_o   : combinational, 1 when cnt_o == DIV-1
// -----------------------------------------------------------------------------
module disp_tick_gen #(
    parameter int unsigned DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [$clog2(DIV)-1:0]  cnt_o,
    output logic                    tick_c_o
);

    localparam int unsigned CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_c_o = (cnt_q == CNT_W'(DIV - 1));

    // Wrap to zero after the last slot cycle
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick_c_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/disp_scan_mux.sv
// -----------------------------------------------------------------------------
// disp_scan_mux
// Time-multiplexed scanner for a 4-digit common-anode display. Loaded values
// are held in a pending buffer and committed only at the frame boundary so a
// frame never shows a mix of old and new digits. Each slot starts with BLANK
// dark cycles to avoid ghosting between digits.
//   clk, rst_n : clock, async active-low reset
//   bus        : disp_scan_mux_if.slave (value/control in, display drive out)
// -----------------------------------------------------------------------------
module disp_scan_mux
    import disp_pkg::*;
#(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    disp_scan_mux_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(DIV);

    logic [CNT_W-1:0]       cnt;
    logic                   tick;

    digit_idx_t             idx_q,         idx_d;
    disp_val_t              pend_q,        pend_d;
    logic                   pending_q,     pending_d;
    disp_val_t              disp_val_q,    disp_val_d;
    nibble_t                nib_q,         nib_d;
    logic [NUM_DIGITS-1:0]  an_n_q,        an_n_d;
    logic                   dp_n_q,        dp_n_d;
    logic                   frame_start_q, frame_start_d;

    logic                   boundary_c;
    disp_val_t              upper_c;
    logic                   blank_c;
    logic                   lit_c;

    disp_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt_o    (cnt),
        .tick_c_o (tick)
    );

    // Last cycle of digit 3 closes the frame
    assign boundary_c = tick && (idx_q == digit_idx_t'(NUM_DIGITS - 1));

    // Nibbles from the current digit upward; all zero means a leading zero
    assign upper_c = disp_val_q >> {idx_q, 2'b00};
    assign blank_c = bus.lz_en && (idx_q != '0) && (upper_c == '0);
    assign lit_c   = (cnt >= CNT_W'(BLANK)) && !blank_c;

    // Next-state: digit index, double-buffered value, registered drive
    always_comb begin
        idx_d         = idx_q;
        pend_d        = pend_q;
        pending_d     = pending_q;
        disp_val_d    = disp_val_q;
        frame_start_d = boundary_c;

        if (tick) begin
            idx_d = idx_q + digit_idx_t'(1);
        end

        if (boundary_c) begin
            // A load landing on the boundary bypasses the buffer
            if (bus.load) begin
                disp_val_d = bus.value_in;
                pending_d  = 1'b0;
            end else if (pending_q) begin
                disp_val_d = pend_q;
                pending_d  = 1'b0;
            end
        end else if (bus.load) begin
            pend_d    = bus.value_in;
            pending_d = 1'b1;
        end

        nib_d  = disp_val_q[{idx_q, 2'b00} +: NIB_W];
        an_n_d = lit_c ? anode_sel(idx_q) : ANODE_OFF;
        dp_n_d = !(lit_c && bus.dp_in[idx_q]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q         <= '0;
            pend_q        <= '0;
            pending_q     <= 1'b0;
            disp_val_q    <= '0;
            nib_q         <= '0;
            an_n_q        <= ANODE_OFF;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            pend_q        <= pend_d;
            pending_q     <= pending_d;
            disp_val_q    <= disp_val_d;
            nib_q         <= nib_d;
            an_n_q        <= an_n_d;
            dp_n_q        <= dp_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.nib         = nib_q;
    assign bus.an_n        = an_n_q;
    assign bus.dp_n        = dp_n_q;
    assign bus.frame_start = frame_start_q;
    assign bus.pending     = pending_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_disp_scan_mux
// Directed bench for disp_scan_mux with DIV=8, BLANK=2. Outputs are sampled
// on the falling edge; expected anode/nibble patterns per slot are given as
// hand-written tables.
// -----------------------------------------------------------------------------
module tb_disp_scan_mux;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_pass;

    disp_scan_mux_if bus ();

    disp_scan_mux #(
        .DIV   (8),
        .BLANK (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for the next frame_start pulse
    task automatic wait_frame(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.frame_start) seen = 1'b1;
        end
        check({tag, " frame_start seen"}, 32'(seen), 32'd1);
    endtask

    // Called on a frame_start cycle; walks the following 32 cycles.
    // nibs: expected nibble per slot; ans: lit anode pattern per slot
    // (4'hF = digit blanked); dpm: slots whose decimal point is requested.
    task automatic scan_frame(input string tag, input logic [15:0] nibs,
                              input logic [15:0] ans, input logic [3:0] dpm);
        int       low_cnt [4];
        int       slot;
        int       c;
        logic [3:0] exp_an;
        logic [3:0] exp_nib;
        logic       exp_dp;
        for (int s = 0; s < 4; s++) low_cnt[s] = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            slot    = (k - 1) / 8;
            c       = (k - 1) % 8;
            exp_an  = (c < 2) ? 4'hF : ans[slot*4 +: 4];
            exp_nib = nibs[slot*4 +: 4];
            exp_dp  = (exp_an != 4'hF && dpm[slot]) ? 1'b0 : 1'b1;
            if (bus.an_n != 4'hF) low_cnt[slot]++;
            check($sformatf("%s an_n k=%0d", tag, k), 32'(bus.an_n), 32'(exp_an));
            check($sformatf("%s nib k=%0d", tag, k), 32'(bus.nib), 32'(exp_nib));
            check($sformatf("%s dp_n k=%0d", tag, k), 32'(bus.dp_n), 32'(exp_dp));
            check($sformatf("%s frame_start k=%0d", tag, k), 32'(bus.frame_start),
                  32'(k == 32));
        end
        for (int s = 0; s < 4; s++) begin
            check($sformatf("%s lit cycles slot %0d", tag, s), 32'(low_cnt[s]),
                  (ans[s*4 +: 4] == 4'hF) ? 32'd0 : 32'd6);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        bus.value_in = '0;
        bus.load     = 1'b0;
        bus.dp_in    = '0;
        bus.lz_en    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst an_n",        32'(bus.an_n),        32'hF);
        check("rst dp_n",        32'(bus.dp_n),        32'd1);
        check("rst nib",         32'(bus.nib),         32'd0);
        check("rst frame_start", 32'(bus.frame_start), 32'd0);
        check("rst pending",     32'(bus.pending),     32'd0);

        // 1234 loaded in the first frame, committed at its boundary
        rst_n        = 1'b1;
        bus.load     = 1'b1;
        bus.value_in = 16'h1234;
        @(negedge clk);
        bus.load = 1'b0;
        check("1234 pending set", 32'(bus.pending),     32'd1);
        check("1234 no fs yet",   32'(bus.frame_start), 32'd0);
        wait_frame("1234");
        check("1234 pending clr", 32'(bus.pending), 32'd0);
        scan_frame("h1234", 16'h1234, 16'h7BDE, 4'h0);

        // Leading-zero suppression on 0050
        bus.lz_en    = 1'b1;
        bus.load     = 1'b1;
        bus.value_in = 16'h0050;
        @(negedge clk);
        bus.load = 1'b0;
        wait_frame("0050");
        scan_frame("h0050", 16'h0050, 16'hFFDE, 4'h0);

        // All-zero value: only digit 0 lit
        bus.load     = 1'b1;
        bus.value_in = 16'h0000;
        @(negedge clk);
        bus.load = 1'b0;
        wait_frame("0000");
        scan_frame("h0000", 16'h0000, 16'hFFFE, 4'h0);

        // AAAA in slot 1 then BBBB in slot 2: last load wins at the boundary
        bus.lz_en = 1'b0;
        repeat (8) @(negedge clk);
        bus.load     = 1'b1;
        bus.value_in = 16'hAAAA;
        @(negedge clk);
        bus.load = 1'b0;
        check("AAAA pending", 32'(bus.pending), 32'd1);
        repeat (7) @(negedge clk);
        bus.load     = 1'b1;
        bus.value_in = 16'hBBBB;
        @(negedge clk);
        bus.load = 1'b0;
        check("BBBB pending", 32'(bus.pending), 32'd1);
        repeat (8) @(negedge clk);
        check("old value in slot 3", 32'(bus.nib),     32'd0);
        check("still pending",       32'(bus.pending), 32'd1);
        wait_frame("BBBB");
        check("BBBB committed", 32'(bus.pending), 32'd0);
        scan_frame("hBBBB", 16'hBBBB, 16'h7BDE, 4'h0);

        // CAFE loaded exactly on the boundary tick bypasses pending
        repeat (31) @(negedge clk);
        check("pre-CAFE pending", 32'(bus.pending), 32'd0);
        bus.load     = 1'b1;
        bus.value_in = 16'hCAFE;
        @(negedge clk);
        bus.load  = 1'b0;
        bus.dp_in = 4'b0100;
        check("CAFE frame_start", 32'(bus.frame_start), 32'd1);
        check("CAFE pending",     32'(bus.pending),     32'd0);
        scan_frame("hCAFE", 16'hCAFE, 16'h7BDE, 4'b0100);

        // Mid-slot async reset discards pend and darkens immediately
        bus.load     = 1'b1;
        bus.value_in = 16'h1111;
        @(negedge clk);
        bus.load = 1'b0;
        check("1111 pending", 32'(bus.pending), 32'd1);
        repeat (19) @(negedge clk);
        check("pre-rst an_n", 32'(bus.an_n), 32'hB);
        check("pre-rst dp_n", 32'(bus.dp_n), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("async rst an_n",    32'(bus.an_n),    32'hF);
        check("async rst dp_n",    32'(bus.dp_n),    32'd1);
        check("async rst pending", 32'(bus.pending), 32'd0);
        check("async rst nib",     32'(bus.nib),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        scan_frame("post-rst", 16'h0000, 16'h7BDE, 4'b0100);
        check("post-rst pending", 32'(bus.pending), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
